multdiv_sequencer: RTL and testbench
====================================

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter RSTATUS_REG, default 30, register receiving exception codes.
REQ-003 SHALL have parameters RSTATUS_MUL, default 4, and RSTATUS_DIV, default 5, exception codes.
REQ-004 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request a mul/div; sampled only in IDLE.
REQ-007 SHALL have port is_div  input  1  1 = divide, 0 = multiply; sampled with start.
REQ-008 SHALL have ports opa, opb  input  WIDTH  signed dividend/multiplicand, divisor/multiplier.
REQ-009 SHALL have port rd  input  5  destination register, latched with start.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE; pipeline stall.
REQ-011 SHALL have port result_valid  output  1  one-cycle pulse in DONE.
REQ-012 SHALL have port result  output  WIDTH  write-back data, meaningful only with result_valid.
REQ-013 SHALL have port wb_rd  output  5  write-back register, meaningful only with result_valid.
REQ-014 SHALL have port exception  output  1  qualifies result_valid; overflow or divide-by-zero.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after exactly WIDTH iteration cycles, DONE->IDLE unconditionally.
REQ-016 SHALL, on start in IDLE, latch is_div, rd, |opa|, |opb| and result sign (opa[MSB] xor opb[MSB]; for div, remainder unused).
REQ-017 SHALL multiply by shift-add of magnitudes, one multiplier bit per RUN cycle, 2*WIDTH-bit accumulator.
REQ-018 SHALL divide by restoring division of magnitudes, one quotient bit per RUN cycle, quotient truncated toward zero.
REQ-019 SHALL negate the magnitude result in DONE when the latched sign is 1.
REQ-020 SHALL flag mul overflow when the signed 2*WIDTH-bit product's upper WIDTH+1 bits are not all equal; result = low WIDTH bits.
REQ-021 SHALL, for divide with opb = 0 at start, go IDLE->DONE directly (result_valid one cycle after start), result = 0, exception = 1.
REQ-022 SHALL, when exception = 1, drive wb_rd = RSTATUS_REG and result = RSTATUS_MUL or RSTATUS_DIV by operation; otherwise wb_rd = latched rd.
REQ-023 SHALL treat -2^(WIDTH-1) / -1 as result 0x80000000, no exception.
REQ-024 SHALL ignore start while busy; no queueing.
REQ-025 SHALL give latency start->result_valid of WIDTH+1 cycles (33 at default), 1 cycle for divide-by-zero.
REQ-026 SHALL accept a new start in the cycle after DONE (back-to-back every WIDTH+2 cycles).

Reset
REQ-027 SHALL, when reset = 0 at a rising edge, enter IDLE and clear all registers; busy, result_valid, exception, result, wb_rd = 0.
REQ-028 SHALL abandon any operation in progress on reset mid-RUN/DONE with no result_valid emitted afterwards.
REQ-029 SHALL ignore start in any cycle where reset = 0.

Structure
REQ-030 SHALL place state encoding (IDLE=0, RUN=1, DONE=2) and the RSTATUS constants in the shared cpu package.
REQ-031 SHALL use one sub-module, twos_negate (conditional two's-complement negate, WIDTH param), for operand magnitude and result sign fix.
REQ-032 SHALL hold the iteration counter as a log2(WIDTH)+1-bit down-counter loaded on start.

Verification
REQ-033 SHALL check mul opa=7, opb=-3 -> result_valid at cycle 33, result=0xFFFFFFEB, exception=0, wb_rd=rd.
REQ-034 SHALL check div opa=-17, opb=5 -> cycle 33, result=0xFFFFFFFD, exception=0.
REQ-035 SHALL check div opa=10, opb=0 -> cycle 1, exception=1, result=5, wb_rd=30.
REQ-036 SHALL check mul opa=0x00010000, opb=0x00010000 -> cycle 33, exception=1, result=4, wb_rd=30.
REQ-037 SHALL check reset=0 at cycle 10 of a RUN -> busy=0 next cycle, no result_valid for 40 cycles.
REQ-038 SHALL check start pulsed at cycle 5 of a RUN -> ignored; exactly one result_valid, for the first operation.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents:
//   state_t                 - sequencer state encoding (IDLE=0, RUN=1, DONE=2)
//   RSTATUS_*_DEFAULT       - default status register index and exception codes
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int RSTATUS_REG_DEFAULT = 30;
    localparam int RSTATUS_MUL_DEFAULT = 4;
    localparam int RSTATUS_DIV_DEFAULT = 5;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Request / write-back bundle between the pipeline and the mul/div sequencer.
// Handshake: the pipeline raises start (with is_div, opa, opb, rd) for one
// cycle; it is accepted only on a cycle where busy is low. busy then stays
// high until the result has been delivered. result_valid is a single-cycle
// pulse; result, wb_rd and exception are meaningful only while it is high.
// There is no back-pressure on the result side.
// Modports:
//   master - the pipeline (drives the request, observes status/result)
//   slave  - the sequencer
interface multdiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [4:0]       rd;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [4:0]       wb_rd;
    logic             exception;

    modport master (
        output start, is_div, opa, opb, rd,
        input  busy, result_valid, result, wb_rd, exception
    );

    modport slave (
        input  start, is_div, opa, opb, rd,
        output busy, result_valid, result, wb_rd, exception
    );
endinterface

// File: rtl/multdiv_sequencer_twos_negate.sv
// twos_negate: conditional two's-complement negation.
// Ports:
//   value  - input operand
//   negate - when 1, result = -value; otherwise result = value
//   result - output
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    assign result = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed multiply / divide unit.
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, one bit per cycle, then applies the result sign. Overflowing
// multiplies and divides by zero are reported as an exception that writes
// an exception code into the status register instead of rd.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low
//   bus   - request / write-back bundle (slave side)
//   state - current sequencer state, for observation
import multdiv_sequencer_pkg::*;

module multdiv_sequencer #(
    parameter int WIDTH       = 32,
    parameter int RSTATUS_REG = RSTATUS_REG_DEFAULT,
    parameter int RSTATUS_MUL = RSTATUS_MUL_DEFAULT,
    parameter int RSTATUS_DIV = RSTATUS_DIV_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    multdiv_sequencer_if.slave    bus,
    output state_t                state
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q;
    logic              div_q, sign_q, dz_q;
    logic [4:0]        rd_q;
    logic [WIDTH-1:0]  opnd_q;   // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] acc_q;   // mul: {partial, multiplier}; div: {remainder, quotient}

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] mag_res, signed_res;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               accept, div_by_zero, mul_ovf;

    assign state = state_q;

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (
        .value(bus.opa), .negate(bus.opa[WIDTH-1]), .result(mag_a));
    twos_negate #(.WIDTH(WIDTH)) u_neg_b (
        .value(bus.opb), .negate(bus.opb[WIDTH-1]), .result(mag_b));
    twos_negate #(.WIDTH(2*WIDTH)) u_neg_res (
        .value(mag_res), .negate(sign_q), .result(signed_res));

    assign accept      = (state_q == ST_IDLE) && bus.start;
    assign div_by_zero = bus.is_div && (bus.opb == '0);

    // One iteration step. Shift-add keeps the partial product in the upper
    // half with one carry bit, shifting the used multiplier bit out at the
    // bottom. Restoring division shifts the next dividend bit into the
    // remainder and keeps the difference only if it did not borrow.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_comb begin
        if (!div_q)
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Quotient magnitude 2^(WIDTH-1) with a positive sign (-2^(WIDTH-1) / -1)
    // simply wraps into the low bits; only the multiply checks overflow.
    assign mag_res = div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
    assign mul_ovf = !((&signed_res[2*WIDTH-1:WIDTH-1]) ||
                       (~|signed_res[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clock) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.busy         = 1'b0;
        bus.result_valid = 1'b0;
        bus.exception    = 1'b0;
        bus.result       = '0;
        bus.wb_rd        = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start)
                    state_d = div_by_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (count_q == CW'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d          = ST_IDLE;
                bus.busy         = 1'b1;
                bus.result_valid = 1'b1;
                bus.exception    = dz_q || (!div_q && mul_ovf);
                if (bus.exception) begin
                    bus.wb_rd  = 5'(RSTATUS_REG);
                    bus.result = div_q ? WIDTH'(RSTATUS_DIV) : WIDTH'(RSTATUS_MUL);
                end else begin
                    bus.wb_rd  = rd_q;
                    bus.result = signed_res[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            div_q   <= 1'b0;
            sign_q  <= 1'b0;
            dz_q    <= 1'b0;
            rd_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
        end else if (accept) begin
            count_q <= CW'(WIDTH);
            div_q   <= bus.is_div;
            sign_q  <= bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1];
            dz_q    <= div_by_zero;
            rd_q    <= bus.rd;
            opnd_q  <= bus.is_div ? mag_b : mag_a;
            acc_q   <= {{WIDTH{1'b0}}, (bus.is_div ? mag_a : mag_b)};
        end else if (state_q == ST_RUN) begin
            count_q <= count_q - CW'(1);
            acc_q   <= acc_next;
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Testbench for multdiv_sequencer: directed and random mul/div operations
// with a behavioural reference model feeding an expected-result queue,
// plus reset-abort and start-while-busy scenarios.
import multdiv_sequencer_pkg::*;

module tb_multdiv_sequencer;
    localparam int W = 32;

    logic   clock;
    logic   reset;
    state_t state;

    int n_tests = 0;
    int n_fail  = 0;

    // {latency[7:0], exception, wb_rd[4:0], result[31:0]}
    logic [45:0] exp_q[$];

    multdiv_sequencer_if #(.WIDTH(W)) bus ();

    multdiv_sequencer #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave),
        .state(state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [45:0] model(input logic d, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] r);
        longint      sa, sb, q;
        logic [63:0] p;
        logic        e;
        logic [31:0] res;
        logic [7:0]  lat;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 8'd33;
        if (d) begin
            if (b == 32'd0) begin
                e   = 1'b1;
                res = 32'd5;
                lat = 8'd1;
            end else begin
                q   = sa / sb;
                p   = q;
                e   = 1'b0;
                res = p[31:0];
            end
        end else begin
            p   = sa * sb;
            e   = !((p[63:31] == 33'd0) || (p[63:31] == {33{1'b1}}));
            res = e ? 32'd4 : p[31:0];
        end
        return {lat, e, (e ? 5'd30 : r), res};
    endfunction

    // ---------------- driver ----------------
    // inject > 0: pulse start with other operands in that cycle of the run.
    task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int inject);
        logic [45:0] e;
        int          n;
        int          extra;
        logic        seen;
        n = 0;
        @(negedge clock);
        while (bus.busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("idle_wait", bus.busy, 0);
        bus.start  = 1'b1;
        bus.is_div = d;
        bus.opa    = a;
        bus.opb    = b;
        bus.rd     = r;
        exp_q.push_back(model(d, a, b, r));
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n = 1;
        seen = 1'b0;
        check("busy_after_start", bus.busy, 1);
        while (!seen && n <= 50) begin
            if (bus.result_valid) begin
                seen = 1'b1;
            end else begin
                if (inject != 0 && n == inject) begin
                    bus.start  = 1'b1;
                    bus.is_div = ~d;
                    bus.opa    = $urandom;
                    bus.opb    = $urandom_range(1, 1000);
                    bus.rd     = 5'(~r);
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clock);
                #1;
                n++;
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            check("result_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("result",    bus.result,    e[31:0]);
            check("wb_rd",     bus.wb_rd,     e[36:32]);
            check("exception", bus.exception, e[37]);
            check("latency",   n,             e[45:38]);
        end
        if (inject != 0) begin
            extra = 0;
            repeat (40) begin
                @(posedge clock);
                #1;
                if (bus.result_valid) extra++;
            end
            check("extra_valid", extra, 0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  bus.busy,         0);
        check({tag, "_valid"}, bus.result_valid, 0);
        check({tag, "_exc"},   bus.exception,    0);
        check({tag, "_res"},   bus.result,       0);
        check({tag, "_wbrd"},  bus.wb_rd,        0);
        check({tag, "_state"}, state,            ST_IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int extra;
        logic d;
        logic [31:0] a, b;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.is_div = 1'b0;
        bus.opa    = '0;
        bus.opb    = '0;
        bus.rd     = '0;
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset");
        reset = 1'b1;

        // directed cases
        run_op(1'b0, 32'd7, -32'sd3, 5'd3, 0);
        run_op(1'b1, -32'sd17, 32'd5, 5'd4, 0);
        run_op(1'b1, 32'd10, 32'd0, 5'd7, 0);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd9, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(1'b0, 32'h8000_0000, 32'd1, 5'd12, 0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        run_op(1'b1, 32'd100, -32'sd7, 5'd14, 0);

        // start pulsed during a run is ignored
        run_op(1'b0, 32'd1234, 32'd5678, 5'd15, 5);

        // reset in cycle 10 of a run abandons it
        @(negedge clock);
        bus.start  = 1'b1;
        bus.is_div = 1'b0;
        bus.opa    = 32'd99;
        bus.opb    = 32'd3;
        bus.rd     = 5'd21;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_quiet("mid_reset");
        reset = 1'b1;
        extra = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.result_valid) extra++;
        end
        check("valid_after_reset", extra, 0);

        // random operations
        for (int i = 0; i < 16; i++) begin
            d = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 40) - 20; end
                2: begin a = $urandom; b = $urandom_range(0, 2) - 1; end
                default: begin a = $urandom_range(0, 65535); b = $urandom_range(0, 65535); end
            endcase
            run_op(d, a, b, 5'($urandom_range(0, 31)), 0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
